// File: rtl/pe_tree_acc_if.sv
// Beat/result bundle for pe_tree_acc: flattened activation/kernel lanes in, accumulated dot product out.
interface pe_tree_acc_if #(
  parameter int LANES    = 8,
  parameter int ELE_BITS = 8,
  parameter int OUT_BITS = 32
);
  logic [LANES*ELE_BITS-1:0] act_flat;
  logic [LANES*ELE_BITS-1:0] ker_flat;
  logic                      valid_in;
  logic                      final_in;
  logic                      valid_out;
  logic [OUT_BITS-1:0]       out_sum;

  // Valid-only flow: a beat transfers on every edge where valid_in is high
  // (final_in is meaningful only then); there is no ready, so the consumer
  // must take out_sum on the single cycle valid_out is high.
  modport master (
    output act_flat, ker_flat, valid_in, final_in,
    input  valid_out, out_sum
  );

  modport slave (
    input  act_flat, ker_flat, valid_in, final_in,
    output valid_out, out_sum
  );
endinterface

// File: rtl/pe_tree_acc.sv
// Pipelined LANES-wide dot-product PE: products, log2(LANES) adder-tree levels, group accumulator.
// Optional macro PE_ACC_SAT_EN: clamp the accumulator instead of wrapping it.
module pe_tree_acc #(
  parameter int LANES      = 8,
  parameter int ELE_BITS   = 8,
  parameter int OUT_BITS   = 32,
  parameter int ACT_SIGNED = 1
) (
  input  logic        clk,
  input  logic        reset,
  pe_tree_acc_if.slave bus
);
  localparam int K  = $clog2(LANES);
  localparam int PW = 2*ELE_BITS + 1;
  localparam int TW = PW + K;
  localparam int NS = K + 2;

  // Tag index: 0 = input capture, 1 = products, 1+l = tree level l.
  logic [NS-1:0]             v_tag;
  logic [NS-1:0]             f_tag;
  logic [LANES*ELE_BITS-1:0] act_q;
  logic [LANES*ELE_BITS-1:0] ker_q;
  logic signed [PW-1:0]      prod [LANES];
  logic signed [TW-1:0]      tree_sum;

  logic signed [OUT_BITS-1:0] acc;
  logic signed [OUT_BITS-1:0] acc_base;
  logic signed [OUT_BITS-1:0] acc_next;
  logic                       restart;
  logic                       pulse;
  logic [OUT_BITS-1:0]        result;

  function automatic logic signed [ELE_BITS:0] act_ext(input logic [ELE_BITS-1:0] a);
    return (ACT_SIGNED != 0) ? {a[ELE_BITS-1], a} : {1'b0, a};
  endfunction

  function automatic logic signed [ELE_BITS:0] ker_ext(input logic [ELE_BITS-1:0] k);
    return {k[ELE_BITS-1], k};
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_tag <= '0;
      f_tag <= '0;
    end else begin
      v_tag <= {v_tag[NS-2:0], bus.valid_in};
      f_tag <= {f_tag[NS-2:0], bus.valid_in & bus.final_in};
    end
  end

  always_ff @(posedge clk) begin
    act_q <= bus.act_flat;
    ker_q <= bus.ker_flat;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++)
      prod[i] <= PW'(act_ext(act_q[i*ELE_BITS +: ELE_BITS])) *
                 PW'(ker_ext(ker_q[i*ELE_BITS +: ELE_BITS]));
  end

  generate
    for (genvar l = 1; l <= K; l++) begin : g_lvl
      localparam int NW = PW + l;
      logic signed [NW-1:0] node [LANES >> l];
      if (l == 1) begin : g_src
        always_ff @(posedge clk) begin
          for (int j = 0; j < (LANES >> l); j++)
            node[j] <= NW'(prod[2*j]) + NW'(prod[2*j+1]);
        end
      end else begin : g_src
        always_ff @(posedge clk) begin
          for (int j = 0; j < (LANES >> l); j++)
            node[j] <= NW'(g_lvl[l-1].node[2*j]) + NW'(g_lvl[l-1].node[2*j+1]);
        end
      end
    end
  endgenerate

  assign tree_sum = g_lvl[K].node[0];
  assign acc_base = restart ? '0 : acc;

`ifdef PE_ACC_SAT_EN
  localparam int SW  = (TW > OUT_BITS) ? TW : OUT_BITS;
  localparam int SW1 = SW + 1;
  localparam logic signed [SW:0] SAT_HI = SW1'($signed({1'b0, {(OUT_BITS-1){1'b1}}}));
  localparam logic signed [SW:0] SAT_LO = SW1'($signed({1'b1, {(OUT_BITS-1){1'b0}}}));
  logic signed [SW:0] sum_wide;

  // One spare bit above both operands keeps the sum exact before clamping.
  always_comb begin
    sum_wide = SW1'(acc_base) + SW1'(tree_sum);
    acc_next = sum_wide[OUT_BITS-1:0];
    if (sum_wide > SAT_HI)
      acc_next = {1'b0, {(OUT_BITS-1){1'b1}}};
    else if (sum_wide < SAT_LO)
      acc_next = {1'b1, {(OUT_BITS-1){1'b0}}};
  end
`else
  always_comb begin
    acc_next = acc_base + OUT_BITS'(tree_sum);
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc     <= '0;
      restart <= 1'b1;
      pulse   <= 1'b0;
      result  <= '0;
    end else begin
      pulse <= v_tag[NS-1] & f_tag[NS-1];
      if (v_tag[NS-1]) begin
        acc     <= acc_next;
        restart <= f_tag[NS-1];
        if (f_tag[NS-1])
          result <= acc_next;
      end
    end
  end

  assign bus.valid_out = pulse;
  assign bus.out_sum   = result;
endmodule

// File: doc/pe_tree_acc.md
Name: pe_tree_acc

Overview:
- Parametrised successor to the fixed 8-element dot-product PE.
- Each valid beat multiplies LANES activation/kernel pairs, reduces them through a fully pipelined log2(LANES)-level adder tree, and accumulates across beats.
- Emits a one-cycle-valid result when the beat tagged final leaves the pipeline, then restarts the accumulation automatically.
- Sits in the DLA compute array, fed by the activation/kernel buffers.

Parameters:
- LANES, 8: elements per beat; power of 2, range 2..32.
- ELE_BITS, 8: activation/kernel element width.
- OUT_BITS, 32: accumulator/result width; must be >= 2*ELE_BITS + log2(LANES).
- ACT_SIGNED, 1: 1 = activations are two's complement; 0 = activations are unsigned (post-ReLU), zero-extended. Kernels are always signed.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- act_flat  in  LANES*ELE_BITS  activations; lane i at bits [i*ELE_BITS +: ELE_BITS].
- ker_flat  in  LANES*ELE_BITS  kernels, same packing as act_flat.
- valid_in  in  1  beat valid.
- final_in  in  1  last beat of the current group; qualified by valid_in.
- valid_out  out  1  one-cycle pulse; out_sum holds a new result.
- out_sum  out  OUT_BITS  signed accumulated dot product.

Behaviour:
- Reset is asynchronous and active-low; clk and reset are the only clock and reset.
- Values while reset is low:
  - all pipeline valid/final tags = 0.
  - accumulator = 0.
  - restart flag = 1.
  - valid_out = 0, out_sum = 0.
- Reset asserted mid-group discards all in-flight beats. The first valid beat after release starts a fresh group.
- Pipeline registers, in order:
  - stage0: input capture.
  - stage1: LANES signed products, each 2*ELE_BITS+1 bits so that the ACT_SIGNED=0 operand range is covered.
  - tree stages T1..Tk, k = log2(LANES): each level adds adjacent pairs and grows the width by 1 bit.
  - acc stage.
- valid_in and final_in travel as tags alongside the data. Data registers are enable-free. Only the tags qualify the data.
- Latency LAT = 2 + log2(LANES) (5 for LANES=8). If a final beat is sampled at edge n, valid_out is high during the cycle following edge n+LAT.
- Acc stage, on edge with tree tag valid:
  - acc_next = (restart ? 0 : acc) + sign_ext(tree_sum).
  - restart <= final tag.
- Beats with valid_in=0 are ignored completely. final_in with valid_in=0 is ignored.
- On a valid final beat: out_sum <= acc_next, valid_out <= 1 for exactly one cycle.
- out_sum holds its value until the next final beat completes.
- A single-beat group (valid_in=1, final_in=1) yields that beat's tree sum.
- Back-to-back groups are supported with no bubble: a beat following a final beat on the next cycle starts a new group, with no contamination from the previous group.
- Throughput: one beat per cycle. There is no backpressure.
- Arithmetic:
  - Products and tree sums are exact.
  - The accumulator wraps modulo 2^OUT_BITS, unless the optional feature is enabled.

Optional Feature:
- Macro: PE_ACC_SAT_EN.
- Defined: each accumulate is computed in OUT_BITS+1 bits, then clamped to [-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1]. The clamped value is the value stored and output.
- Undefined: two's-complement wrap. No extra logic.
- Ports and latency are identical in both builds.

Test Plan:
- Reset: drive 3 valid beats, then pull reset low at the edge the 2nd beat enters the tree, release, and send one final beat with act=1, ker=1 -> valid_out=0 and out_sum=0 during reset; the single result afterwards is 8.
- Single beat, LANES=8: act=1, ker=2 on all lanes, valid_in=1, final_in=1 at edge n -> valid_out pulses once after edge n+5, out_sum=16.
- Signed multi-beat: act=0xFF (-1), ker=3 on all lanes, 3 consecutive beats, final on the 3rd -> out_sum=-72 (0xFFFFFFB8), exactly one valid_out pulse.
- Gaps and back-to-back groups:
  - Group A: act=2, ker=1, final on beat 2; idle cycles between its beats carry act=0x7F with valid_in=0.
  - Group B starts on the very next cycle after A's final, with act=1, ker=-1, single beat, final.
  - Required: two pulses, 1 cycle apart, A=32 then B=-8.
- Extremes:
  - ACT_SIGNED=1, act=0x80, ker=0x80 on all lanes -> single-beat out_sum=131072.
  - ACT_SIGNED=0, act=0xFF, ker=0x01 -> out_sum=2040.
  - ACT_SIGNED=0, act=0xFF, ker=0xFF -> out_sum=-2040.
- Saturation, OUT_BITS=20: 4 beats of act=0x80, ker=0x80, final on the 4th (total 524288) -> 524287 with PE_ACC_SAT_EN defined, -524288 without.
